status_flag_unit: RTL and testbench
===================================

Name: status_flag_unit

Overview:
- Upstream neighbour of the condition-check stage; owns the architectural NZCV status register.
- Supplies `status_out` in the {Z,C,N,V} packing that the condition checker consumes.
- Tracks flag-setting instructions in flight between ID and EX.
- Raises `flags_stall` when a conditional instruction in ID would otherwise read stale flags, with an optional EX→ID flag bypass.

Parameters:
- EX_DIST, 1, stages from ID to EX inclusive of EX (legal 1..4); depth of the pending tracker.
- BYPASS, 0, 1 = forward EX-stage flags to `status_out` combinationally; 0 = no forwarding.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- freeze  input  1  hazard-unit bubble request; ID instruction not issued this cycle
- flush  input  1  taken-branch flush; ID instruction killed this cycle
- id_cond_valid  input  1  ID instruction has a condition other than AL (4'b1110)
- id_s  input  1  ID instruction sets flags (S bit)
- ex_s_valid  input  1  EX instruction passed its condition, has S=1, and writes flags this cycle
- ex_flags  input  4  new flags from ALU, {Z,C,N,V}
- status_out  output  4  flags presented to condition check, {Z,C,N,V}
- flags_stall  output  1  hold ID, insert bubble
- pending_cnt  output  3  number of flag-setting instructions in flight (population count of the tracker)

Behaviour:
- Reset (rst==0 at posedge):
  - flag_reg=4'b0000 and pend=0.
  - Consequently status_out=0 (ex_s_valid is ignored during reset), flags_stall=0, pending_cnt=0.
  - Reset mid-operation discards all pending state; no flag write occurs that cycle.
- Flag register:
  - At posedge, if ex_s_valid, then flag_reg<=ex_flags. Otherwise it holds.
  - Not gated by freeze, flush or flags_stall, because the EX stage always retires its own update.
- status_out:
  - BYPASS=1 and ex_s_valid: ex_flags, combinational, same cycle.
  - Otherwise: flag_reg.
  - Latency of a flag write is therefore 1 cycle with BYPASS=0 and 0 cycles with BYPASS=1.
- Issue qualifier: issue_s = id_s & ~freeze & ~flush & ~flags_stall.
- Pending tracker pend[EX_DIST-1:0], a shift register:
  - Entry 0 is the instruction one stage past ID; entry EX_DIST-1 is the instruction in EX.
  - Each posedge: pend[0]<=issue_s and pend[i]<=pend[i-1].
  - The tracker shifts every cycle. Bubbles enter as 0, so a stall or freeze never freezes the tracker.
  - flush clears only the incoming entry; older entries are past the branch and keep shifting.
  - ex_s_valid does not clear entries. An EX instruction that fails its condition simply ages out.
- Stall:
  - flags_stall = id_cond_valid & |mask(pend), combinational.
  - mask = all entries when BYPASS=0.
  - mask = entries 0..EX_DIST-2 when BYPASS=1, because the EX entry is forwarded.
  - With EX_DIST=1 and BYPASS=1, flags_stall is constantly 0.
- An unconditional instruction (AL) never stalls, even with writers pending.
- A conditional S instruction stalls like any conditional instruction; once released it issues and sets pend[0].
- Simultaneous freeze & flags_stall: both are asserted independently; the bubble is the same.
- Simultaneous flush & flags_stall: the stall output still follows the formula; the hazard unit gives flush priority.
- Stall duration ≤ EX_DIST cycles (BYPASS=0) or ≤ EX_DIST-1 cycles (BYPASS=1).
- pending_cnt saturates naturally, since EX_DIST ≤ 4 and the counter is 3 bits.

Decomposition:
- Shared package:
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - Condition encoding constants COND_EQ=4'b0000 … COND_AL=4'b1110.
  - Width constant FLAGS_W=4.
  - The condition-check stage imports the same package.
- One sub-module, flag_pend_tracker:
  - Parameterised shift register plus masked-OR and popcount.
  - Instantiated once.
  - The top level holds flag_reg, the bypass mux and the stall formula.

Test Plan:
- Reset: drive rst=0 for 2 cycles with ex_s_valid=1, ex_flags=4'b1111 → status_out=0000, pending_cnt=0, flags_stall=0. Release reset → flag_reg still 0000.
- Write latency, BYPASS=0: ex_s_valid=1, ex_flags=4'b0100 in cycle t → status_out=0100 from t+1. With BYPASS=1 → 0100 in cycle t itself.
- RAW stall, EX_DIST=2, BYPASS=0:
  - ID issues id_s=1 at t.
  - Conditional instruction in ID at t+1 → flags_stall=1 at t+1 and t+2, 0 at t+3.
  - pending_cnt sequence: 1, 1, 0.
- Same stimulus with BYPASS=1 → stall only at t+1. At t+2, status_out equals ex_flags when ex_s_valid=1.
- Flush/freeze kill: id_s=1 together with flush=1 (repeat with freeze=1) → pend[0]=0 next cycle, pending_cnt=0, and a following conditional instruction does not stall.
- AL and failed-condition writer:
  - id_cond_valid=0 with pending_cnt=2 → flags_stall=0.
  - An EX writer with ex_s_valid=0 → flag_reg unchanged and the entry ages out after EX_DIST cycles.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status-flag unit and the condition-check stage.
// Flags are packed {Z,C,N,V}, MSB first.
package status_flag_unit_pkg;

  localparam int unsigned FLAGS_W     = 4;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned EX_DIST_MAX = 4;

  // Bit positions inside a flags word
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef logic [FLAGS_W-1:0] flags_t;

  // Build a flags word from individual flag bits
  function automatic flags_t pack_flags(input logic z, input logic c,
                                        input logic n, input logic v);
    return {z, c, n, v};
  endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// Pipeline-side bus of the status-flag unit.
// master: pipeline / hazard logic (drives ID/EX info, receives status)
// slave : status_flag_unit
interface status_flag_unit_if;
  import status_flag_unit_pkg::*;

  logic             freeze;
  logic             flush;
  logic             id_cond_valid;
  logic             id_s;
  logic             ex_s_valid;
  flags_t           ex_flags;
  flags_t           status_out;
  logic             flags_stall;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output freeze, flush, id_cond_valid, id_s, ex_s_valid, ex_flags,
    input  status_out, flags_stall, pending_cnt
  );

  modport slave (
    input  freeze, flush, id_cond_valid, id_s, ex_s_valid, ex_flags,
    output status_out, flags_stall, pending_cnt
  );
endinterface

// File: rtl/status_flag_unit_flag_pend_tracker.sv
// Shift register of in-flight flag-setting instructions between ID and EX.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   issue_i    - a flag-setting instruction leaves ID this cycle
//   hit_o      - OR of the entries that still hazard a conditional reader
//   cnt_o      - number of occupied entries
module flag_pend_tracker
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_i,
  output logic             hit_o,
  output logic [CNT_W-1:0] cnt_o
);

  // With bypass the EX entry (top bit) is forwarded, so it is excluded
  localparam logic [DEPTH-1:0] MASK =
    BYPASS ? DEPTH'((1 << (DEPTH - 1)) - 1) : {DEPTH{1'b1}};

  logic [DEPTH-1:0] pend_q, pend_d;

  // Shift every cycle; bubbles enter as zero
  always_comb begin
    pend_d    = '0;
    pend_d[0] = issue_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      pend_d[i] = pend_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  // Population count of the tracker
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_o = cnt_o + CNT_W'(pend_q[i]);
    end
  end

  assign hit_o = |(pend_q & MASK);

endmodule

// File: rtl/status_flag_unit.sv
// Owner of the architectural NZCV register; supplies flags to the condition
// check and stalls conditional ID instructions that would read stale flags.
// Ports:
//   clk, rst - clock, synchronous active-low reset
//   bus      - slave side of status_flag_unit_if (freeze, flush,
//              id_cond_valid, id_s, ex_s_valid, ex_flags in;
//              status_out, flags_stall, pending_cnt out)
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned EX_DIST = 1,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  status_flag_unit_if.slave bus
);

  flags_t           flag_q, flag_d;
  logic             stall_c;
  logic             hit;
  logic             issue_s;
  logic [CNT_W-1:0] cnt;

  // EX always retires its own flag update, independent of ID-side hazards
  always_comb begin
    flag_d = flag_q;
    if (bus.ex_s_valid) flag_d = bus.ex_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst) flag_q <= '0;
    else      flag_q <= flag_d;
  end

  assign issue_s = bus.id_s & ~bus.freeze & ~bus.flush & ~stall_c;

  flag_pend_tracker #(
    .DEPTH  (EX_DIST),
    .BYPASS (BYPASS)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .issue_i (issue_s),
    .hit_o   (hit),
    .cnt_o   (cnt)
  );

  assign stall_c = bus.id_cond_valid & hit & rst;

  // Forward EX flags in the same cycle; a write under reset is ignored
  always_comb begin
    bus.status_out = flag_q;
    if (BYPASS && bus.ex_s_valid && rst) bus.status_out = bus.ex_flags;
  end

  assign bus.flags_stall = stall_c;
  assign bus.pending_cnt = cnt;

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;
  import status_flag_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       freeze, flush, id_cond_valid, id_s, ex_s_valid;
  logic [3:0] ex_flags;

  int errors = 0;
  int checks = 0;

  status_flag_unit_if sfu0 ();
  status_flag_unit_if sfu1 ();
  status_flag_unit_if sfu2 ();

  assign sfu0.freeze = freeze;        assign sfu1.freeze = freeze;        assign sfu2.freeze = freeze;
  assign sfu0.flush = flush;          assign sfu1.flush = flush;          assign sfu2.flush = flush;
  assign sfu0.id_cond_valid = id_cond_valid;
  assign sfu1.id_cond_valid = id_cond_valid;
  assign sfu2.id_cond_valid = id_cond_valid;
  assign sfu0.id_s = id_s;            assign sfu1.id_s = id_s;            assign sfu2.id_s = id_s;
  assign sfu0.ex_s_valid = ex_s_valid;
  assign sfu1.ex_s_valid = ex_s_valid;
  assign sfu2.ex_s_valid = ex_s_valid;
  assign sfu0.ex_flags = ex_flags;    assign sfu1.ex_flags = ex_flags;    assign sfu2.ex_flags = ex_flags;

  status_flag_unit #(.EX_DIST(2), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(sfu0.slave));
  status_flag_unit #(.EX_DIST(2), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(sfu1.slave));
  status_flag_unit #(.EX_DIST(4), .BYPASS(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(sfu2.slave));

  // ---------------- reference model ----------------
  // Each issued writer is remembered by the cycle it left ID; its age in
  // cycles tells whether it is still between ID and EX.
  typedef struct { int k; int t; } wr_t;
  wr_t        wq[$];
  int         cyc     = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_flag  = 4'b0000;

  function automatic int exd(int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic bit byp(int k);
    return (k != 0);
  endfunction

  function automatic bit m_stall(int k);
    int lim;
    lim = byp(k) ? exd(k) - 1 : exd(k);
    if (!rst || !id_cond_valid) return 1'b0;
    foreach (wq[i]) begin
      if (wq[i].k == k && (cyc - wq[i].t) >= 1 && (cyc - wq[i].t) <= lim) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_cnt(int k);
    int n = 0;
    foreach (wq[i]) begin
      if (wq[i].k == k && (cyc - wq[i].t) >= 1 && (cyc - wq[i].t) <= exd(k)) n++;
    end
    return n;
  endfunction

  function automatic logic [3:0] m_status(int k);
    if (byp(k) && ex_s_valid && rst) return ex_flags;
    return m_flag;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] st [3];
    logic       sl [3];
    logic [2:0] cn [3];
    if (!m_valid) return;
    st[0] = sfu0.status_out; sl[0] = sfu0.flags_stall; cn[0] = sfu0.pending_cnt;
    st[1] = sfu1.status_out; sl[1] = sfu1.flags_stall; cn[1] = sfu1.pending_cnt;
    st[2] = sfu2.status_out; sl[2] = sfu2.flags_stall; cn[2] = sfu2.pending_cnt;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s model status dut%0d", tag, k), st[k], m_status(k));
      chk($sformatf("%s model stall dut%0d", tag, k), 4'(sl[k]), 4'(m_stall(k)));
      chk($sformatf("%s model cnt dut%0d", tag, k), 4'(cn[k]), 4'(m_cnt(k)));
    end
  endtask

  // Advance model across the next rising edge using the current inputs
  task automatic model_tick();
    bit iss [3];
    for (int k = 0; k < 3; k++)
      iss[k] = rst && id_s && !freeze && !flush && !m_stall(k);
    @(posedge clk);
    if (!rst) begin
      wq.delete();
      m_flag  = 4'b0000;
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) if (iss[k]) wq.push_back('{k, cyc});
      if (ex_s_valid) m_flag = ex_flags;
    end
    cyc++;
    for (int i = wq.size() - 1; i >= 0; i--)
      if (cyc - wq[i].t > 4) wq.delete(i);
  endtask

  task automatic drive(input logic r, input logic frz, input logic fl, input logic cnd,
                       input logic s, input logic exv, input logic [3:0] exf);
    @(negedge clk);
    rst = r; freeze = frz; flush = fl; id_cond_valid = cnd;
    id_s = s; ex_s_valid = exv; ex_flags = exf;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r, frz, fl, cnd, s, exv;
    logic [3:0] exf;
    bit chk;
    logic [3:0] st0; logic sl0; logic [2:0] c0;
    logic [3:0] st1; logic sl1; logic [2:0] c1;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, frz, fl, cnd, s, exv, input logic [3:0] exf,
                              input bit c, input logic [3:0] st0, input logic sl0,
                              input logic [2:0] c0, input logic [3:0] st1,
                              input logic sl1, input logic [2:0] c1);
    vec_t v;
    v.r = r; v.frz = frz; v.fl = fl; v.cnd = cnd; v.s = s; v.exv = exv; v.exf = exf;
    v.chk = c; v.st0 = st0; v.sl0 = sl0; v.c0 = c0; v.st1 = st1; v.sl1 = sl1; v.c1 = c1;
    return v;
  endfunction

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; id_cond_valid = 1'b0;
    id_s = 1'b0; ex_s_valid = 1'b0; ex_flags = 4'h0;

    //            r  fz fl cd s  ev exf  ck st0  sl0 c0 st1  sl1 c1
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0); // reset, state unknown
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 4'hF, 1, 4'h0, 0, 0, 4'h0, 0, 0); // write ignored in reset
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 0, 0); // released: still 0
    vecs[3]  = mk(1, 0, 0, 0, 0, 1, 4'h4, 1, 4'h0, 0, 0, 4'h4, 0, 0); // write: bypass same cycle
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h4, 0, 0, 4'h4, 0, 0); // registered next cycle
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 4'h0, 1, 4'h4, 0, 0, 4'h4, 0, 0); // writer issues (t)
    vecs[6]  = mk(1, 0, 0, 1, 0, 0, 4'h0, 1, 4'h4, 1, 1, 4'h4, 1, 1); // t+1 both stall
    vecs[7]  = mk(1, 0, 0, 1, 0, 1, 4'h9, 1, 4'h4, 1, 1, 4'h9, 0, 1); // t+2 bypass releases
    vecs[8]  = mk(1, 0, 0, 1, 0, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0); // t+3 released
    vecs[9]  = mk(1, 0, 1, 0, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0); // writer flushed
    vecs[10] = mk(1, 0, 0, 1, 0, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0);
    vecs[11] = mk(1, 1, 0, 0, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0); // writer frozen
    vecs[12] = mk(1, 0, 0, 1, 0, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0); // two AL writers
    vecs[14] = mk(1, 0, 0, 0, 1, 0, 4'h0, 1, 4'h9, 0, 1, 4'h9, 0, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 2, 4'h9, 0, 2); // AL with cnt 2
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 1, 4'h9, 0, 1); // failed writers age out
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0); // conditional S sequence
    vecs[19] = mk(1, 0, 0, 1, 1, 0, 4'h0, 1, 4'h9, 1, 1, 4'h9, 1, 1);
    vecs[20] = mk(1, 0, 0, 1, 1, 0, 4'h0, 1, 4'h9, 1, 1, 4'h9, 0, 1);
    vecs[21] = mk(1, 0, 0, 1, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 1, 1);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 1, 4'h9, 0, 1);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 1, 4'h9, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 1, 0, 4'h0, 1, 4'h9, 0, 0, 4'h9, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 1, 4'h6, 1, 4'h9, 0, 1, 4'h9, 0, 1); // reset mid-operation
    vecs[26] = mk(1, 0, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 0, 0); // all state discarded

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].r, vecs[i].frz, vecs[i].fl, vecs[i].cnd, vecs[i].s,
            vecs[i].exv, vecs[i].exf);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d status0", i), sfu0.status_out, vecs[i].st0);
        chk($sformatf("v%0d stall0", i), 4'(sfu0.flags_stall), 4'(vecs[i].sl0));
        chk($sformatf("v%0d cnt0", i), 4'(sfu0.pending_cnt), 4'(vecs[i].c0));
        chk($sformatf("v%0d status1", i), sfu1.status_out, vecs[i].st1);
        chk($sformatf("v%0d stall1", i), 4'(sfu1.flags_stall), 4'(vecs[i].sl1));
        chk($sformatf("v%0d cnt1", i), 4'(sfu1.pending_cnt), 4'(vecs[i].c1));
      end
      model_check($sformatf("v%0d", i));
      model_tick();
    end

    // ---------------- randomized phase ----------------
    for (int n = 0; n < 3000; n++) begin
      drive(logic'($urandom_range(99) >= 2),
            logic'($urandom_range(9) == 0),
            logic'($urandom_range(9) == 0),
            logic'($urandom_range(1)),
            logic'($urandom_range(9) < 4),
            logic'($urandom_range(9) < 3),
            4'($urandom_range(15)));
      model_check($sformatf("r%0d", n));
      model_tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
